ps2_rx_fifo: RTL and testbench

- Parametrised PS/2-style serial receiver and the successor to the fixed 8-bit bench-driven link.
- Synchronises and filters the external clk/dat pair and deserialises frames of configurable width and parity mode.
- Detects framing, parity and timeout errors.
- Buffers received words, each with its error flags, in a FIFO drained by a valid/ready consumer inside the tap.

---
 rtl/ps2_rx_pkg.sv | 16 +
 rtl/ps2_rx_fifo_sync_fifo.sv | 53 +++++
 rtl/ps2_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_pkg.sv
// Shared types and helpers for the PS/2 receiver: parity modes, FSM states, frame length.
package ps2_rx_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} rx_state_e;

   // Start + payload + optional parity + stop.
   function automatic int unsigned frame_bits(input int unsigned data_bits,
                                              input int unsigned parity_mode);
      return data_bits + ((parity_mode != PAR_NONE) ? 32'd3 : 32'd2);
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head; level counts every stored entry.
module sync_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr, rptr_nxt_c;
   logic [LW-1:0]    lvl_nxt_c, lvl_after_pop_c;
   logic             do_push_c, do_pop_c;

   // A push into a full FIFO is accepted only when the head leaves on the same edge.
   assign do_pop_c        = pop & ~empty;
   assign do_push_c       = push & (~full | do_pop_c);
   assign rptr_nxt_c      = rptr + AW'(do_pop_c);
   assign lvl_after_pop_c = level - LW'(do_pop_c);
   assign lvl_nxt_c       = lvl_after_pop_c + LW'(do_push_c);

   always_ff @(posedge clk) begin
      if (do_push_c) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         rdata <= '0;
      end else begin
         if (do_push_c) wptr <= wptr + AW'(1);
         rptr  <= rptr_nxt_c;
         level <= lvl_nxt_c;
         full  <= (lvl_nxt_c == LW'(DEPTH));
         empty <= (lvl_after_pop_c == '0);
         if (lvl_after_pop_c != '0) rdata <= mem[rptr_nxt_c];
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2-style receiver: sync + glitch filter, frame FSM with parity/stop/timeout checks, FWFT FIFO.
// Optional statistics counters are built when PS2_RX_STATS_EN is defined.
module ps2_rx_fifo
   import ps2_rx_pkg::*;
#(
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned PARITY_MODE    = 1,
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2000,
   parameter int unsigned DEPTH          = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ps2_clk,
   input  logic                   ps2_dat,
   output logic [DATA_BITS-1:0]   out_data,
   output logic                   out_perr,
   output logic                   out_ferr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   ovf,
   input  logic                   ovf_clr,
   output logic [$clog2(DEPTH):0] level
`ifdef PS2_RX_STATS_EN
   ,
   input  logic                   stats_clr,
   output logic [15:0]            stat_frames,
   output logic [15:0]            stat_perr,
   output logic [15:0]            stat_ferr
`endif
);
   localparam int unsigned FW = $clog2(FILTER_LEN);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned EW = DATA_BITS + 2;

   logic [1:0]           rst_sync;
   logic                 rst_n;
   logic [1:0]           clk_sync, dat_sync;
   logic [1:0]           raw_c, filt;
   logic [FW-1:0]        fcnt [2];
   logic                 fclk_q, strobe_c, sdat_c;
   rx_state_e            state;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_q, xr_c;
   logic [TW-1:0]        tmo_cnt;
   logic                 push_q, fifo_empty, fifo_full, drop_c;
   logic [EW-1:0]        push_data_q, fifo_rdata;

   // Asynchronous assert, synchronous release of the internal reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
      end
   end
   assign raw_c = {dat_sync[1], clk_sync[1]};

   // Filtered line flips only after FILTER_LEN consecutive opposite samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt    <= 2'b11;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (raw_c[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
               filt[i] <= raw_c[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + FW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fclk_q <= 1'b1;
      else        fclk_q <= filt[0];
   end
   assign strobe_c = fclk_q & ~filt[0];
   assign sdat_c   = filt[1];
   assign xr_c     = (^shreg) ^ sdat_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         perr_q      <= 1'b0;
         tmo_cnt     <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (state == IDLE) begin
            tmo_cnt <= '0;
            if (strobe_c && !sdat_c) begin
               state   <= DATA;
               bit_cnt <= '0;
               shreg   <= '0;
               perr_q  <= 1'b0;
            end
         end else if (strobe_c) begin
            tmo_cnt <= '0;
            case (state)
               DATA: begin
                  shreg   <= {sdat_c, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + BW'(1);
                  if (bit_cnt == BW'(DATA_BITS - 1))
                     state <= (PARITY_MODE != PAR_NONE) ? PAR : STOP;
               end
               PAR: begin
                  perr_q <= (PARITY_MODE == PAR_EVEN) ? xr_c : ~xr_c;
                  state  <= STOP;
               end
               STOP: begin
                  push_q      <= 1'b1;
                  push_data_q <= {shreg, perr_q, ~sdat_c};
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Line clock stalled mid-frame: flush what was shifted so far as a framing error.
            push_q      <= 1'b1;
            push_data_q <= {shreg, 1'b0, 1'b1};
            state       <= IDLE;
            tmo_cnt     <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

   sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_q),
      .wdata (push_data_q),
      .pop   (out_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign {out_data, out_perr, out_ferr} = fifo_rdata;
   assign out_valid = ~fifo_empty;
   assign drop_c    = push_q & fifo_full & ~(out_ready & out_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ovf <= 1'b0;
      else if (drop_c)  ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

`ifdef PS2_RX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_frames <= '0;
         stat_perr   <= '0;
         stat_ferr   <= '0;
      end else if (stats_clr) begin
         stat_frames <= '0;
         stat_perr   <= '0;
         stat_ferr   <= '0;
      end else if (push_q) begin
         if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
         if (push_data_q[1] && stat_perr != 16'hFFFF) stat_perr <= stat_perr + 16'd1;
         if (push_data_q[0] && stat_ferr != 16'hFFFF) stat_ferr <= stat_ferr + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: default 8-bit odd-parity instance plus a 9-bit even-parity instance.
module tb_ps2_rx_fifo;
   import ps2_rx_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       lclk = 1'b1, ldat = 1'b1, sel_b = 1'b0;
   logic       a_clk, a_dat, b_clk, b_dat;
   logic       out_ready = 1'b0, ovf_clr = 1'b0;
   logic [7:0] a_data;
   logic       a_perr, a_ferr, a_valid, a_ovf;
   logic [3:0] a_level;
   logic [8:0] b_data;
   logic       b_perr, b_ferr, b_valid, b_ovf;
   logic [3:0] b_level;
   int         n_tests = 0, n_fail = 0;

   assign a_clk = sel_b ? 1'b1 : lclk;
   assign a_dat = sel_b ? 1'b1 : ldat;
   assign b_clk = sel_b ? lclk : 1'b1;
   assign b_dat = sel_b ? ldat : 1'b1;

   always #50 clk = ~clk;

   ps2_rx_fifo u_dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(a_clk), .ps2_dat(a_dat),
      .out_data(a_data), .out_perr(a_perr), .out_ferr(a_ferr), .out_valid(a_valid),
      .out_ready(out_ready), .ovf(a_ovf), .ovf_clr(ovf_clr), .level(a_level)
`ifdef PS2_RX_STATS_EN
      , .stats_clr(1'b0), .stat_frames(), .stat_perr(), .stat_ferr()
`endif
   );

   ps2_rx_fifo #(.DATA_BITS(9), .PARITY_MODE(2)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .ps2_clk(b_clk), .ps2_dat(b_dat),
      .out_data(b_data), .out_perr(b_perr), .out_ferr(b_ferr), .out_valid(b_valid),
      .out_ready(1'b0), .ovf(b_ovf), .ovf_clr(1'b0), .level(b_level)
`ifdef PS2_RX_STATS_EN
      , .stats_clr(1'b0), .stat_frames(), .stat_perr(), .stat_ferr()
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Holds the line clock at lvl for half cycles, optionally with a 2-cycle opposite glitch.
   task automatic hold(input int half, input logic lvl, input bit glitch);
      lclk = lvl;
      if (glitch) begin
         nclk(15); lclk = ~lvl; nclk(2); lclk = lvl; nclk(half - 17);
      end else begin
         nclk(half);
      end
   endtask

   task automatic send_frame(input logic [15:0] d, input int nbits, input int pmode,
                             input int half, input bit flip_par, input bit bad_stop,
                             input bit glitch);
      logic [31:0] bits;
      logic        p;
      int          nb;
      nb = int'(frame_bits(nbits, pmode));
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p ^= d[i];
      if (pmode == int'(PAR_ODD)) p = ~p;
      p ^= flip_par;
      bits = '0;
      for (int i = 0; i < nbits; i++) bits[1+i] = d[i];
      if (pmode != 0) bits[nbits+1] = p;
      bits[nb-1] = ~bad_stop;
      for (int i = 0; i < nb; i++) begin
         ldat = bits[i];
         hold(half, 1'b1, glitch);
         hold(half, 1'b0, glitch);
         lclk = 1'b1;
      end
      ldat = 1'b1;
      nclk(30);
   endtask

   // Start bit plus the first k data bits; optionally leaves the line clock stuck low.
   task automatic send_partial(input logic [15:0] d, input int k, input int half, input bit hold_low);
      ldat = 1'b0; nclk(half); lclk = 1'b0; nclk(half); lclk = 1'b1;
      for (int i = 0; i < k; i++) begin
         ldat = d[i]; nclk(half); lclk = 1'b0;
         if (!(hold_low && i == k - 1)) begin
            nclk(half); lclk = 1'b1;
         end
      end
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] d, input logic p, input logic f);
      @(negedge clk);
      chk({tag, " valid"}, 32'(a_valid), 32'd1);
      chk({tag, " data"}, 32'(a_data), 32'(d));
      chk({tag, " perr"}, 32'(a_perr), 32'(p));
      chk({tag, " ferr"}, 32'(a_ferr), 32'(f));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      nclk(5);
      chk("rst valid", 32'(a_valid), 32'd0);
      chk("rst data", 32'(a_data), 32'd0);
      chk("rst perr", 32'(a_perr), 32'd0);
      chk("rst ferr", 32'(a_ferr), 32'd0);
      chk("rst ovf", 32'(a_ovf), 32'd0);
      chk("rst level", 32'(a_level), 32'd0);
      reset_n = 1'b1;
      nclk(10);

      // Three frames at 10 kHz and 16.7 kHz line clocks.
      send_frame(16'h00, 8, 1, 500, 0, 0, 0);
      send_frame(16'hA5, 8, 1, 300, 0, 0, 0);
      send_frame(16'hFF, 8, 1, 300, 0, 0, 0);
      chk("three level", 32'(a_level), 32'd3);
      pop_chk("w0", 8'h00, 0, 0);
      pop_chk("w1", 8'hA5, 0, 0);
      pop_chk("w2", 8'hFF, 0, 0);
      chk("drained valid", 32'(a_valid), 32'd0);
      chk("drained level", 32'(a_level), 32'd0);

      send_frame(16'h3C, 8, 1, 50, 1, 0, 0);
      pop_chk("bad parity", 8'h3C, 1, 0);
      send_frame(16'h3C, 8, 1, 50, 0, 1, 0);
      pop_chk("bad stop", 8'h3C, 0, 1);

      // Overflow: ten frames into an eight-entry FIFO.
      for (int i = 0; i < 10; i++) send_frame(16'(8'h10 + i), 8, 1, 50, 0, 0, 0);
      chk("full level", 32'(a_level), 32'd8);
      chk("ovf set", 32'(a_ovf), 32'd1);
      for (int i = 0; i < 8; i++) pop_chk("ovf word", 8'(8'h10 + i), 0, 0);
      chk("ovf sticky", 32'(a_ovf), 32'd1);
      ovf_clr = 1'b1; nclk(1); ovf_clr = 1'b0; nclk(1);
      chk("ovf clr", 32'(a_ovf), 32'd0);

      // Line clock stuck low after four data bits (1,0,1,0 -> bits 0,1,0,1 of 0xA).
      send_partial(16'h000A, 4, 50, 1);
      nclk(1900);
      chk("tmo early level", 32'(a_level), 32'd0);
      nclk(200);
      chk("tmo level", 32'(a_level), 32'd1);
      lclk = 1'b1; ldat = 1'b1; nclk(30);
      pop_chk("tmo word", 8'hA0, 0, 1);
      send_frame(16'h5A, 8, 1, 50, 0, 0, 0);
      pop_chk("after tmo", 8'h5A, 0, 0);

      send_frame(16'h81, 8, 1, 50, 0, 0, 1);
      chk("glitch level", 32'(a_level), 32'd1);
      pop_chk("glitch word", 8'h81, 0, 0);

      // Reset mid-frame discards both the FIFO and the partial frame.
      send_frame(16'h77, 8, 1, 50, 0, 0, 0);
      chk("pre-rst level", 32'(a_level), 32'd1);
      send_partial(16'h0005, 3, 50, 0);
      reset_n = 1'b0; nclk(5);
      chk("midrst level", 32'(a_level), 32'd0);
      reset_n = 1'b1; ldat = 1'b1; nclk(10);
      send_frame(16'h42, 8, 1, 50, 0, 0, 0);
      chk("post-rst level", 32'(a_level), 32'd1);
      pop_chk("post-rst word", 8'h42, 0, 0);
      chk("post-rst empty", 32'(a_valid), 32'd0);

      // 9-bit even-parity instance.
      sel_b = 1'b1;
      nclk(5);
      send_frame(16'h01F3, 9, 2, 50, 0, 0, 0);
      @(negedge clk);
      chk("b valid", 32'(b_valid), 32'd1);
      chk("b data", 32'(b_data), 32'h1F3);
      chk("b perr", 32'(b_perr), 32'd0);
      chk("b ferr", 32'(b_ferr), 32'd0);
      chk("b level", 32'(b_level), 32'd1);
      chk("b ovf", 32'(b_ovf), 32'd0);
      chk("a idle level", 32'(a_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
